// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bundle for the shared-ALU arbiter.
// Latency: none, this file only groups wires.
// Backpressure: valid/ready on both request ports and on the response port.
//   slave  : arbiter view (takes requests and ALU results, drives ALU operands and response)
//   master : environment view (issue logic, ALU and response consumer)
interface alu_share_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             r0_valid;
    logic             r0_ready;
    logic [63:0]      r0_src1;
    logic [63:0]      r0_src2;
    logic [11:0]      r0_op;
    logic [TAG_W-1:0] r0_tag;

    logic             r1_valid;
    logic             r1_ready;
    logic [63:0]      r1_src1;
    logic [63:0]      r1_src2;
    logic [11:0]      r1_op;
    logic [TAG_W-1:0] r1_tag;

    logic [63:0]      alu_src1;
    logic [63:0]      alu_src2;
    logic [11:0]      alu_op;
    logic [63:0]      alu_data_rd;
    logic [63:0]      alu_dnpc1;
    logic [63:0]      alu_dnpc2;
    logic [31:0]      alu_raddr;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [63:0]      rsp_data;
    logic [63:0]      rsp_dnpc1;
    logic [63:0]      rsp_dnpc2;
    logic [31:0]      rsp_raddr;

    modport slave (
        input  r0_valid, r0_src1, r0_src2, r0_op, r0_tag,
        input  r1_valid, r1_src1, r1_src2, r1_op, r1_tag,
        input  alu_data_rd, alu_dnpc1, alu_dnpc2, alu_raddr,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output alu_src1, alu_src2, alu_op,
        output rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_dnpc1, rsp_dnpc2, rsp_raddr
    );

    modport master (
        output r0_valid, r0_src1, r0_src2, r0_op, r0_tag,
        output r1_valid, r1_src1, r1_src2, r1_op, r1_tag,
        output alu_data_rd, alu_dnpc1, alu_dnpc2, alu_raddr,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  alu_src1, alu_src2, alu_op,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_dnpc1, rsp_dnpc2, rsp_raddr
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational 64-bit ALU between the EXU (port 0) and LSU address gen (port 1).
// Latency: grant and ALU drive in the request cycle; registered response valid the next cycle.
// Backpressure: no grant while the response register is full and rsp_ready is low; 1 op/cycle when drained.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus.r0_* / bus.r1_*   : request ports (valid/ready, operands, one-hot op, tag)
//   bus.alu_*             : operands out to the ALU and its results back
//   bus.rsp_*             : one-entry response register (valid/ready, id, tag, captured results)
module alu_share_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4,
    parameter int TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;   // 1 = port 1 was granted last
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic [63:0]      rsp_dnpc1_q, rsp_dnpc1_d;
    logic [63:0]      rsp_dnpc2_q, rsp_dnpc2_d;
    logic [31:0]      rsp_raddr_q, rsp_raddr_d;

    logic can_accept;
    logic gnt0;
    logic gnt1;

    // Grant selection: only one port can be granted, and only if the
    // response slot is free now or is being drained this same cycle.
    always_comb begin
        can_accept = (state_q == EMPTY) || bus.rsp_ready;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (can_accept) begin
            if (bus.r0_valid && bus.r1_valid) begin
                if (PRIO_MODE == 0) begin
                    gnt1 = ~last_grant_q;
                end else begin
                    gnt1 = (wait_cnt_q == MAX_WAIT_C);
                end
                gnt0 = ~gnt1;
            end else begin
                gnt0 = bus.r0_valid;
                gnt1 = bus.r1_valid;
            end
        end
    end

    assign bus.r0_ready = gnt0;
    assign bus.r1_ready = gnt1;

    // ALU operands are zero in idle cycles so the ALU sees op=0.
    always_comb begin
        bus.alu_src1 = '0;
        bus.alu_src2 = '0;
        bus.alu_op   = '0;
        if (gnt0) begin
            bus.alu_src1 = bus.r0_src1;
            bus.alu_src2 = bus.r0_src2;
            bus.alu_op   = bus.r0_op;
        end else if (gnt1) begin
            bus.alu_src1 = bus.r1_src1;
            bus.alu_src2 = bus.r1_src2;
            bus.alu_op   = bus.r1_op;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_data_d   = rsp_data_q;
        rsp_dnpc1_d  = rsp_dnpc1_q;
        rsp_dnpc2_d  = rsp_dnpc2_q;
        rsp_raddr_d  = rsp_raddr_q;

        if (gnt0 || gnt1) begin
            state_d      = FULL;
            last_grant_d = gnt1;
            rsp_id_d     = gnt1;
            rsp_tag_d    = gnt1 ? bus.r1_tag : bus.r0_tag;
            rsp_data_d   = bus.alu_data_rd;
            rsp_dnpc1_d  = bus.alu_dnpc1;
            rsp_dnpc2_d  = bus.alu_dnpc2;
            rsp_raddr_d  = bus.alu_raddr;
        end else if (bus.rsp_ready) begin
            state_d = EMPTY;
        end

        // Starvation guard counts how long port 1 has been refused in a row.
        if (PRIO_MODE == 0) begin
            wait_cnt_d = '0;
        end else if (!bus.r1_valid || gnt1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_data_q   <= '0;
            rsp_dnpc1_q  <= '0;
            rsp_dnpc2_q  <= '0;
            rsp_raddr_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_data_q   <= rsp_data_d;
            rsp_dnpc1_q  <= rsp_dnpc1_d;
            rsp_dnpc2_q  <= rsp_dnpc2_d;
            rsp_raddr_q  <= rsp_raddr_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_dnpc1 = rsp_dnpc1_q;
    assign bus.rsp_dnpc2 = rsp_dnpc2_q;
    assign bus.rsp_raddr = rsp_raddr_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 round-robin, instance 1 fixed priority (MAX_WAIT=4).
// Latency: checks grant in the request cycle and the response one cycle later.
// Backpressure: exercises rsp_ready low with pending requests on both ports.
module tb_alu_share_arbiter;

    localparam int MAXW = 4;
    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_JAL = 12'h800;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus, indexed [dut][port]
    logic        vld  [2][2];
    logic [63:0] s1   [2][2];
    logic [63:0] s2   [2][2];
    logic [11:0] opv  [2][2];
    logic [3:0]  tg   [2][2];
    logic        rrdy [2];

    // DUT observation
    logic        got_rdy  [2][2];
    logic [11:0] got_op   [2];
    logic [63:0] got_s1   [2];
    logic [63:0] got_s2   [2];
    logic        got_rvld [2];
    logic        got_id   [2];
    logic [3:0]  got_tag  [2];
    logic [63:0] got_data [2];
    logic [63:0] got_d1   [2];
    logic [63:0] got_d2   [2];
    logic [31:0] got_ra   [2];

    // Behavioural ALU stub
    function automatic logic [63:0] alu_data(input logic [11:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[0])       return a + b;
        else if (op[1])  return a - b;
        else if (op[2])  return a & b;
        else if (op[3])  return a | b;
        else if (op[4])  return a ^ b;
        else if (op[11]) return a + 64'd4;
        return 64'd0;
    endfunction

    alu_share_arbiter_if #(.TAG_W(4)) bus [2] ();

    alu_share_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAXW), .TAG_W(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus[0]));
    alu_share_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAXW), .TAG_W(4)) u_pr (
        .clk(clk), .rst_n(rst_n), .bus(bus[1]));

    for (genvar d = 0; d < 2; d++) begin : g_bus
        assign bus[d].r0_valid    = vld[d][0];
        assign bus[d].r0_src1     = s1[d][0];
        assign bus[d].r0_src2     = s2[d][0];
        assign bus[d].r0_op       = opv[d][0];
        assign bus[d].r0_tag      = tg[d][0];
        assign bus[d].r1_valid    = vld[d][1];
        assign bus[d].r1_src1     = s1[d][1];
        assign bus[d].r1_src2     = s2[d][1];
        assign bus[d].r1_op       = opv[d][1];
        assign bus[d].r1_tag      = tg[d][1];
        assign bus[d].rsp_ready   = rrdy[d];
        assign bus[d].alu_data_rd = alu_data(bus[d].alu_op, bus[d].alu_src1, bus[d].alu_src2);
        assign bus[d].alu_dnpc1   = bus[d].alu_src1 + 64'd4;
        assign bus[d].alu_dnpc2   = bus[d].alu_src1 + bus[d].alu_src2;
        assign bus[d].alu_raddr   = 32'(bus[d].alu_src1 + bus[d].alu_src2);
        assign got_rdy[d][0] = bus[d].r0_ready;
        assign got_rdy[d][1] = bus[d].r1_ready;
        assign got_op[d]     = bus[d].alu_op;
        assign got_s1[d]     = bus[d].alu_src1;
        assign got_s2[d]     = bus[d].alu_src2;
        assign got_rvld[d]   = bus[d].rsp_valid;
        assign got_id[d]     = bus[d].rsp_id;
        assign got_tag[d]    = bus[d].rsp_tag;
        assign got_data[d]   = bus[d].rsp_data;
        assign got_d1[d]     = bus[d].rsp_dnpc1;
        assign got_d2[d]     = bus[d].rsp_dnpc2;
        assign got_ra[d]     = bus[d].rsp_raddr;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a one-slot response holder per instance, plus the
    // arbitration history (who won last, how long port 1 has been refused).
    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [63:0] data;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [31:0] ra;
    } rsp_t;

    logic m_full [2];
    rsp_t m_rsp  [2];
    int   m_last [2];
    int   m_age  [2];
    int   m_g    [2];
    logic consumed [2][2];

    logic        snap_rdy0 [2];
    logic        snap_rdy1 [2];
    logic        snap_rvld [2];
    logic        snap_id   [2];
    logic [11:0] snap_op   [2];
    logic [63:0] snap_data [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 1'b0;
            m_last[d] = 1;
            m_age[d]  = 0;
        end
    endtask

    function automatic int model_pick(input int d);
        if (m_full[d] && !rrdy[d]) return -1;
        if (vld[d][0] && vld[d][1]) begin
            if (d == 0) return (m_last[d] == 1) ? 0 : 1;
            return (m_age[d] >= MAXW) ? 1 : 0;
        end
        if (vld[d][0]) return 0;
        if (vld[d][1]) return 1;
        return -1;
    endfunction

    // Compare one cycle before the edge, then advance the model across it.
    task automatic step();
        #2;
        for (int d = 0; d < 2; d++) begin
            int g;
            g = model_pick(d);
            m_g[d] = g;
            chk($sformatf("r0_ready[%0d]", d), got_rdy[d][0], g == 0);
            chk($sformatf("r1_ready[%0d]", d), got_rdy[d][1], g == 1);
            chk($sformatf("alu_op[%0d]", d),   got_op[d], (g < 0) ? 12'd0 : opv[d][g]);
            chk($sformatf("alu_src1[%0d]", d), got_s1[d], (g < 0) ? 64'd0 : s1[d][g]);
            chk($sformatf("alu_src2[%0d]", d), got_s2[d], (g < 0) ? 64'd0 : s2[d][g]);
            chk($sformatf("rsp_valid[%0d]", d), got_rvld[d], m_full[d]);
            if (m_full[d]) begin
                chk($sformatf("rsp_id[%0d]", d),    got_id[d],   m_rsp[d].id);
                chk($sformatf("rsp_tag[%0d]", d),   got_tag[d],  m_rsp[d].tag);
                chk($sformatf("rsp_data[%0d]", d),  got_data[d], m_rsp[d].data);
                chk($sformatf("rsp_dnpc1[%0d]", d), got_d1[d],   m_rsp[d].d1);
                chk($sformatf("rsp_dnpc2[%0d]", d), got_d2[d],   m_rsp[d].d2);
                chk($sformatf("rsp_raddr[%0d]", d), got_ra[d],   m_rsp[d].ra);
            end
            snap_rdy0[d] = got_rdy[d][0];
            snap_rdy1[d] = got_rdy[d][1];
            snap_rvld[d] = got_rvld[d];
            snap_id[d]   = got_id[d];
            snap_op[d]   = got_op[d];
            snap_data[d] = got_data[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int g;
            g = m_g[d];
            if (d == 1) begin
                if (!vld[1][1] || g == 1) m_age[1] = 0;
                else if (m_age[1] < MAXW) m_age[1] = m_age[1] + 1;
            end
            if (g >= 0) begin
                m_full[d]      = 1'b1;
                m_rsp[d].id    = (g == 1);
                m_rsp[d].tag   = tg[d][g];
                m_rsp[d].data  = alu_data(opv[d][g], s1[d][g], s2[d][g]);
                m_rsp[d].d1    = s1[d][g] + 64'd4;
                m_rsp[d].d2    = s1[d][g] + s2[d][g];
                m_rsp[d].ra    = 32'(s1[d][g] + s2[d][g]);
                m_last[d]      = g;
                consumed[d][g] = 1'b1;
            end else if (rrdy[d]) begin
                m_full[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_req(input int d, input int p, input logic v, input logic [11:0] op,
                           input logic [63:0] a, input logic [63:0] b);
        vld[d][p] = v;
        opv[d][p] = op;
        s1[d][p]  = a;
        s2[d][p]  = b;
        tg[d][p]  = a[3:0];
    endtask

    function automatic logic [11:0] pick_op();
        case ($urandom_range(0, 7))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return 12'h004;
            3: return 12'h008;
            4: return 12'h010;
            5: return OP_JAL;
            6: return 12'h000;
            default: return 12'($urandom);
        endcase
    endfunction

    typedef struct {
        logic        v0;
        logic [11:0] op0;
        logic [63:0] a0;
        logic [63:0] b0;
        logic        v1;
        logic [11:0] op1;
        logic [63:0] a1;
        logic [63:0] b1;
        logic        rr;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_rvld;
        logic [63:0] e_data;
        logic        e_id;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [11:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                                input logic v1, input logic [11:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                                input logic rr, input logic er0, input logic er1, input logic ev,
                                input logic [63:0] ed, input logic eid);
        vec_t t;
        t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0;
        t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1;
        t.rr = rr; t.e_rdy0 = er0; t.e_rdy1 = er1; t.e_rvld = ev; t.e_data = ed; t.e_id = eid;
        return t;
    endfunction

    vec_t vecs [14];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rrdy[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                set_req(d, p, 1'b0, 12'd0, 64'd0, 64'd0);
                consumed[d][p] = 1'b0;
            end
        end
        model_reset();
        rst_n = 1'b0;

        // Round-robin instance, starting from reset (port 0 wins first).
        vecs[0]  = mk(1, OP_ADD, 5, 7,           0, 0, 0, 0,          1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,                0, 0, 0, 0,          1, 0, 0, 1, 12, 0);
        vecs[2]  = mk(0, 0, 0, 0,                1, OP_SUB, 3, 5,     1, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,                0, 0, 0, 0,          1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        vecs[4]  = mk(1, OP_ADD, 10, 0,          1, OP_ADD, 1001, 0,  1, 1, 0, 0, 0, 0);
        vecs[5]  = mk(1, OP_ADD, 20, 0,          1, OP_ADD, 1001, 0,  1, 0, 1, 1, 10, 0);
        vecs[6]  = mk(1, OP_ADD, 20, 0,          1, OP_ADD, 1002, 0,  1, 1, 0, 1, 1001, 1);
        vecs[7]  = mk(1, OP_ADD, 30, 0,          1, OP_ADD, 1002, 0,  1, 0, 1, 1, 20, 0);
        vecs[8]  = mk(1, OP_ADD, 30, 0,          1, OP_ADD, 1003, 0,  1, 1, 0, 1, 1002, 1);
        vecs[9]  = mk(1, OP_ADD, 40, 0,          1, OP_ADD, 1003, 0,  1, 0, 1, 1, 30, 0);
        vecs[10] = mk(1, OP_ADD, 40, 0,          0, 0, 0, 0,          1, 1, 0, 1, 1003, 1);
        vecs[11] = mk(1, OP_JAL, 64'h8000_0000, 0, 0, 0, 0, 0,        1, 1, 0, 1, 40, 0);
        vecs[12] = mk(0, 0, 0, 0,                0, 0, 0, 0,          1, 0, 0, 1, 64'h8000_0004, 0);
        vecs[13] = mk(0, 0, 0, 0,                0, 0, 0, 0,          0, 0, 0, 0, 0, 0);

        // Reset state
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset rsp_valid[%0d]", d), got_rvld[d], 0);
            chk($sformatf("reset rsp_data[%0d]", d),  got_data[d], 0);
            chk($sformatf("reset rsp_id[%0d]", d),    got_id[d], 0);
            chk($sformatf("reset rsp_tag[%0d]", d),   got_tag[d], 0);
            chk($sformatf("reset alu_op[%0d]", d),    got_op[d], 0);
            chk($sformatf("reset r0_ready[%0d]", d),  got_rdy[d][0], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors on the round-robin instance
        rrdy[1] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_req(0, 0, vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0);
            set_req(0, 1, vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1);
            rrdy[0] = vecs[i].rr;
            step();
            chk($sformatf("tbl%0d r0_ready", i), snap_rdy0[0], vecs[i].e_rdy0);
            chk($sformatf("tbl%0d r1_ready", i), snap_rdy1[0], vecs[i].e_rdy1);
            chk($sformatf("tbl%0d alu_op", i), snap_op[0],
                vecs[i].e_rdy0 ? vecs[i].op0 : (vecs[i].e_rdy1 ? vecs[i].op1 : 12'd0));
            chk($sformatf("tbl%0d rsp_valid", i), snap_rvld[0], vecs[i].e_rvld);
            if (vecs[i].e_rvld) begin
                chk($sformatf("tbl%0d rsp_data", i), snap_data[0], vecs[i].e_data);
                chk($sformatf("tbl%0d rsp_id", i),   snap_id[0],   vecs[i].e_id);
            end
        end

        // Fixed priority with starvation guard: port 1 wins every 5th cycle
        begin
            int c0, c1;
            logic e1;
            c0 = 0; c1 = 0;
            rrdy[0] = 1'b1;
            set_req(0, 0, 1'b0, 0, 0, 0);
            set_req(0, 1, 1'b0, 0, 0, 0);
            rrdy[1] = 1'b1;
            for (int i = 0; i < 10; i++) begin
                set_req(1, 0, 1'b1, OP_ADD, 64'(200 + c0), 64'd1);
                set_req(1, 1, 1'b1, OP_ADD, 64'(300 + c1), 64'd2);
                step();
                e1 = (i == 4) || (i == 9);
                chk($sformatf("prio%0d r1_ready", i), snap_rdy1[1], e1);
                chk($sformatf("prio%0d r0_ready", i), snap_rdy0[1], !e1);
                if (e1) c1++; else c0++;
            end
            set_req(1, 0, 1'b0, 0, 0, 0);
            set_req(1, 1, 1'b0, 0, 0, 0);
            step();
        end

        // Response held for 10 cycles while both ports wait, then back-to-back grant
        rrdy[0] = 1'b0;
        set_req(0, 0, 1'b1, OP_ADD, 64'd77, 64'd0);
        step();
        chk("hold first grant", snap_rdy0[0], 1);
        set_req(0, 0, 1'b1, OP_ADD, 64'd88, 64'd0);
        set_req(0, 1, 1'b1, OP_ADD, 64'd99, 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("hold%0d readies", i), {snap_rdy0[0], snap_rdy1[0]}, 2'b00);
            chk($sformatf("hold%0d rsp_valid", i), snap_rvld[0], 1);
            chk($sformatf("hold%0d rsp_data", i), snap_data[0], 77);
        end
        rrdy[0] = 1'b1;
        step();
        chk("release r1_ready", snap_rdy1[0], 1);
        chk("release r0_ready", snap_rdy0[0], 0);
        set_req(0, 1, 1'b0, 0, 0, 0);
        step();
        chk("release new data", snap_data[0], 99);
        chk("release new id", snap_id[0], 1);
        set_req(0, 0, 1'b0, 0, 0, 0);
        step();

        // Asynchronous reset while both instances hold a response
        for (int d = 0; d < 2; d++) begin
            rrdy[d] = 1'b0;
            set_req(d, 0, 1'b1, OP_ADD, 64'd500, 64'd3);
        end
        step();
        for (int d = 0; d < 2; d++) set_req(d, 0, 1'b0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async rst rsp_valid[%0d]", d), got_rvld[d], 0);
            chk($sformatf("async rst rsp_data[%0d]", d),  got_data[d], 0);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rrdy[d] = 1'b1;
            set_req(d, 0, 1'b1, OP_ADD, 64'd600, 64'd0);
            set_req(d, 1, 1'b1, OP_SUB, 64'd700, 64'd0);
        end
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post rst first grant[%0d]", d), {snap_rdy0[d], snap_rdy1[d]}, 2'b10);
            set_req(d, 0, 1'b0, 0, 0, 0);
            set_req(d, 1, 1'b0, 0, 0, 0);
            consumed[d][0] = 1'b0;
            consumed[d][1] = 1'b0;
        end
        step();

        // Randomised traffic against the model; requests held until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!vld[d][p] || consumed[d][p]) begin
                        vld[d][p]      = ($urandom_range(0, 99) < 70);
                        opv[d][p]      = pick_op();
                        s1[d][p]       = {$urandom, $urandom};
                        s2[d][p]       = {$urandom, $urandom};
                        tg[d][p]       = 4'($urandom);
                        consumed[d][p] = 1'b0;
                    end
                end
                rrdy[d] = ($urandom_range(0, 99) < 65);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
